ipd_sample_sequencer: RTL
=========================

# ipd_sample_sequencer

Frame sequencer for the I_PD servo control datapath. It runs a programmable sample-period timer and accepts one reference/feedback sample pair per period through a valid/ready handshake. It drives the I_PD `enable` strobe for a fixed compute window, then a settle window, then captures the `IPD` result into a held output with a one-cycle valid pulse for the PWM stage. Period overruns are flagged sticky.

## Interface
- `W`, 18: datapath width (referencia, y, IPD).
- `DIV_W`, 16: width of the sample-period divider.
- `EN_CYCLES`, 5: cycles `ipd_enable` is held high per frame (≥1).
- `SETTLE_CYCLES`, 3: cycles `ipd_enable` is held low before capture (≥1).
- `U_MAX`, 18'sh0FFFF: upper clamp, signed (used only with `IPD_CLAMP_EN`).
- `U_MIN`, -18'sh10000: lower clamp, signed (used only with `IPD_CLAMP_EN`).

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `run`  in  1: enables sampling.
- `sample_div`  in  DIV_W: sample period is `sample_div+1` clk cycles. Sampled at each period restart.
- `ref_in`  in  W: reference sample.
- `y_in`  in  W: plant feedback sample.
- `in_valid`  in  1: sample pair available.
- `in_ready`  out  1: sequencer accepts a pair.
- `overrun_clr`  in  1: clears `overrun`.
- `referencia`  out  W: registered reference to I_PD.
- `y`  out  W: registered feedback to I_PD.
- `ipd_enable`  out  1: I_PD enable.
- `IPD`  in  W: I_PD result, signed.
- `u_out`  out  W: captured control value, held between frames.
- `u_valid`  out  1: one-cycle pulse when `u_out` updates.
- `overrun`  out  1: sticky; set when a period tick occurs outside WAIT_TICK.

## Operation
- **States:** IDLE, WAIT_TICK, WAIT_DATA, RUN, SETTLE, CAPTURE.
- **Reset values:** state IDLE; `in_ready`, `ipd_enable`, `u_valid`, `overrun` are 0; `referencia`, `y`, `u_out` are 0; divider is 0.
- **Divider:** held at 0 in IDLE. Otherwise it counts 0..`sample_div` and wraps to 0. `tick` = (count == `sample_div`), so `sample_div`=0 ticks every cycle.
- **IDLE → WAIT_TICK:** when `run`=1.
- **WAIT_TICK:**
  - `run`=0 → IDLE.
  - `tick` → WAIT_DATA.
- **WAIT_DATA:** `in_ready`=1. On `in_valid`&`in_ready`, latch `ref_in`/`y_in` into `referencia`/`y` and go to RUN.
- **RUN:** `ipd_enable`=1 for exactly EN_CYCLES cycles, then SETTLE.
- **SETTLE:** `ipd_enable`=0 for exactly SETTLE_CYCLES cycles, then CAPTURE.
- **CAPTURE:** one cycle. At its closing edge, `u_out` ← `IPD` (clamped if enabled) and `u_valid` ← 1 for one cycle. Next state is WAIT_TICK if `run`=1, else IDLE.
- **`run` deasserted mid-frame:** the frame completes; return to IDLE after CAPTURE. `run`=0 in WAIT_DATA → IDLE with no capture.
- **Overrun:** `tick` in any state other than WAIT_TICK/IDLE sets `overrun`; that tick is dropped.
- **`overrun_clr` and set in the same cycle:** set wins.
- **`referencia`/`y`:** stable from acceptance until the next acceptance.

## Timing
- Handshake accepted at edge e0: `ipd_enable`=1 from e0 to e0+EN_CYCLES. CAPTURE is the cycle starting at e0+EN_CYCLES+SETTLE_CYCLES. `u_valid`=1 in the cycle starting at e0+EN_CYCLES+SETTLE_CYCLES+1 (edge 9 for defaults).
- Minimum overrun-free period: `sample_div+1` ≥ EN_CYCLES+SETTLE_CYCLES+3, with `in_valid` already high at WAIT_DATA entry.
- Reset mid-frame: the next cycle shows all reset values. No `u_valid` pulse.

## Configuration
- `IPD_CLAMP_EN` defined: `u_out` is the signed clamp of `IPD` to [`U_MIN`,`U_MAX`].
- Not defined: `u_out` = `IPD` unmodified, and `U_MAX`/`U_MIN` are unused.

## Structure
- Shared package `ipd_pkg`: state enum encoding, `W` default, default EN/SETTLE constants.
- One sub-module `ipd_period_timer`: the divider with load of `sample_div` and `tick` output. Everything else stays in the top.

## Test plan
- `sample_div`=19, `run`=1, `in_valid` held high, `IPD`=18'h00123 → `ipd_enable` high 5 cycles / low 3 per 20-cycle period; `u_out`=18'h00123; `u_valid` 9 edges after acceptance; `overrun`=0.
- `in_valid` delayed 4 cycles after WAIT_DATA entry → `in_ready` high 5 cycles; `referencia`/`y` equal the values present at the accepting edge.
- `sample_div`=5 → `overrun`=1 after the first frame; `overrun_clr` pulse clears it; simultaneous tick and clear leave it at 1.
- `reset` asserted during RUN → next cycle `ipd_enable`=0, `u_out`=0, state IDLE, no `u_valid`.
- `run` dropped during SETTLE → frame captures once, then IDLE with `in_ready`=0.
- `IPD_CLAMP_EN` defined, `IPD`=18'h1FFFF (positive beyond `U_MAX`) → `u_out`=18'h0FFFF. `IPD`=18'h20000 → `u_out`=18'h30000 (`U_MIN`).

Source files
------------

// File: rtl/ipd_pkg.sv
// Shared definitions for the I_PD sample sequencer: state encoding,
// default datapath width and default enable/settle window lengths.
package ipd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_RUN       = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_CAPTURE   = 3'd5
  } state_t;

  localparam int IPD_W             = 18;
  localparam int IPD_EN_CYCLES     = 5;
  localparam int IPD_SETTLE_CYCLES = 3;

  // Width of the enable/settle window down-counter.
  localparam int WIN_W = 8;

endpackage

// File: rtl/ipd_period_timer.sv
// Sample-period divider. Counts 0..sample_div and wraps; tick marks the
// last count of each period. The period length is re-sampled at every
// restart so a new sample_div never truncates a period in progress.
module ipd_period_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic [DIV_W-1:0] sample_div,
  output logic             tick
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] div_q;

  assign tick = !hold && (count_q == div_q);

  // Divider count with period reload on hold or wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      div_q   <= '0;
    end else if (hold || tick) begin
      count_q <= '0;
      div_q   <= sample_div;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/ipd_sample_sequencer.sv
// Frame sequencer for the I_PD servo datapath: one sample pair per period,
// enable window, settle window, then capture of the I_PD result.
// Optional feature macro: IPD_CLAMP_EN (signed clamp of the captured value
// to [U_MIN, U_MAX]); without it the result is passed through unmodified.
//
// state        | meaning
// -------------+----------------------------------------------------
// ST_IDLE      | sampling disabled, divider held at 0
// ST_WAIT_TICK | waiting for the period tick
// ST_WAIT_DATA | in_ready high, waiting for a sample pair
// ST_RUN       | ipd_enable high for EN_CYCLES cycles
// ST_SETTLE    | ipd_enable low for SETTLE_CYCLES cycles
// ST_CAPTURE   | one cycle; result registered at its closing edge
module ipd_sample_sequencer
  import ipd_pkg::*;
#(
  parameter int                    W             = IPD_W,
  parameter int                    DIV_W         = 16,
  parameter int                    EN_CYCLES     = IPD_EN_CYCLES,
  parameter int                    SETTLE_CYCLES = IPD_SETTLE_CYCLES,
  parameter logic signed [W-1:0]   U_MAX         = 18'sh0FFFF,
  parameter logic signed [W-1:0]   U_MIN         = -18'sh10000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [DIV_W-1:0] sample_div,
  input  logic [W-1:0]     ref_in,
  input  logic [W-1:0]     y_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             overrun_clr,
  output logic [W-1:0]     referencia,
  output logic [W-1:0]     y,
  output logic             ipd_enable,
  input  logic [W-1:0]     IPD,
  output logic [W-1:0]     u_out,
  output logic             u_valid,
  output logic             overrun
);

  localparam logic [WIN_W-1:0] EN_LOAD     = WIN_W'(EN_CYCLES - 1);
  localparam logic [WIN_W-1:0] SETTLE_LOAD = WIN_W'(SETTLE_CYCLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIN_W-1:0] win_q;
  logic             win_done;
  logic             tick;
  logic             accept;
  logic [W-1:0]     u_next;

  ipd_period_timer #(
    .DIV_W (DIV_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .hold       (state_q == ST_IDLE),
    .sample_div (sample_div),
    .tick       (tick)
  );

  assign win_done = (win_q == '0);
  assign accept   = in_valid && in_ready;

`ifdef IPD_CLAMP_EN
  logic signed [W-1:0] ipd_s;
  assign ipd_s  = signed'(IPD);
  assign u_next = (ipd_s > U_MAX) ? U_MAX :
                  (ipd_s < U_MIN) ? U_MIN : IPD;
`else
  logic unused_clamp;
  assign unused_clamp = ^{U_MAX, U_MIN};
  assign u_next       = IPD;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (run) state_d = ST_WAIT_TICK;
      ST_WAIT_TICK: begin
        if (!run)      state_d = ST_IDLE;
        else if (tick) state_d = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (!run)        state_d = ST_IDLE;
        else if (accept) state_d = ST_RUN;
      end
      ST_RUN:       if (win_done) state_d = ST_SETTLE;
      ST_SETTLE:    if (win_done) state_d = ST_CAPTURE;
      ST_CAPTURE:   state_d = run ? ST_WAIT_TICK : ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Moore outputs; in_ready drops with run so a pair is never taken for a
  // frame that will not execute.
  always_comb begin
    in_ready   = 1'b0;
    ipd_enable = 1'b0;
    unique case (state_q)
      ST_WAIT_DATA: in_ready   = run;
      ST_RUN:       ipd_enable = 1'b1;
      default: ;
    endcase
  end

  // Enable/settle window down-counter, loaded on entry to each window.
  always_ff @(posedge clk) begin
    if (reset)                           win_q <= '0;
    else if (state_q == ST_WAIT_DATA)    win_q <= EN_LOAD;
    else if (state_q == ST_RUN && win_done) win_q <= SETTLE_LOAD;
    else if (!win_done)                  win_q <= win_q - 1'b1;
  end

  // Sample pair latch, stable until the next accepted handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      referencia <= '0;
      y          <= '0;
    end else if (accept) begin
      referencia <= ref_in;
      y          <= y_in;
    end
  end

  // Result capture with a one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      u_out   <= '0;
      u_valid <= 1'b0;
    end else begin
      u_valid <= (state_q == ST_CAPTURE);
      if (state_q == ST_CAPTURE) u_out <= u_next;
    end
  end

  // Sticky overrun: a tick outside the waiting states; set beats clear.
  always_ff @(posedge clk) begin
    if (reset)
      overrun <= 1'b0;
    else if (tick && state_q != ST_WAIT_TICK && state_q != ST_IDLE)
      overrun <= 1'b1;
    else if (overrun_clr)
      overrun <= 1'b0;
  end

endmodule
